// File: rtl/chacha_round_ctrl.sv
// ChaCha block round controller.
// A single combinational quarterround core is time-shared over the 16-word
// working state, one quarterround per cycle: four column rounds, then four
// diagonal rounds, repeated DR times. A final cycle adds the saved input
// state to produce the keystream block.

module chacha_qr (
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [31:0] c_in,
    input  logic [31:0] d_in,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [31:0] c_out,
    output logic [31:0] d_out
);

    logic [31:0] a, b, c, d;

    // ARX quarterround: add, xor, rotate in the fixed 16/12/8/7 pattern.
    always_comb begin
        // NOTE: blocking assignments here model a dataflow chain; each line
        // sees the value produced by the line above in the same evaluation.
        a = a_in;
        b = b_in;
        c = c_in;
        d = d_in;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        a_out = a;
        b_out = b;
        c_out = c;
        d_out = d;
    end

endmodule

module chacha_round_ctrl (
    input  logic         clk,
    input  logic         reset,
    input  logic         init,
    input  logic [4:0]   rounds,
    input  logic [511:0] state_in,
    output logic         ready,
    output logic         valid,
    output logic [511:0] state_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUNDS = 2'd1,
        FINAL  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [15:0][31:0]   work_q, work_d;
    logic [15:0][31:0]   saved_q, saved_d;
    logic [3:0]          dr_q, dr_d;
    logic [3:0]          dr_ctr_q, dr_ctr_d;
    logic [2:0]          qr_idx_q, qr_idx_d;
    logic                valid_q, valid_d;
    logic [511:0]        out_q, out_d;

    logic [3:0]          ia, ib, ic, id;
    logic [31:0]         qa, qb, qc, qd;

    // Word slots feeding ports a,b,c,d for the current quarterround.
    always_comb begin
        ia = 4'd0; ib = 4'd4; ic = 4'd8; id = 4'd12;
        case (qr_idx_q)
            3'd0: begin ia = 4'd0; ib = 4'd4; ic = 4'd8;  id = 4'd12; end
            3'd1: begin ia = 4'd1; ib = 4'd5; ic = 4'd9;  id = 4'd13; end
            3'd2: begin ia = 4'd2; ib = 4'd6; ic = 4'd10; id = 4'd14; end
            3'd3: begin ia = 4'd3; ib = 4'd7; ic = 4'd11; id = 4'd15; end
            3'd4: begin ia = 4'd0; ib = 4'd5; ic = 4'd10; id = 4'd15; end
            3'd5: begin ia = 4'd1; ib = 4'd6; ic = 4'd11; id = 4'd12; end
            3'd6: begin ia = 4'd2; ib = 4'd7; ic = 4'd8;  id = 4'd13; end
            3'd7: begin ia = 4'd3; ib = 4'd4; ic = 4'd9;  id = 4'd14; end
            default: ;
        endcase
    end

    chacha_qr u_qr (
        .a_in  (work_q[ia]),
        .b_in  (work_q[ib]),
        .c_in  (work_q[ic]),
        .d_in  (work_q[id]),
        .a_out (qa),
        .b_out (qb),
        .c_out (qc),
        .d_out (qd)
    );

    assign ready     = (state_q == IDLE);
    assign valid     = valid_q;
    assign state_out = out_q;

    // Next-state and datapath update for the IDLE -> ROUNDS -> FINAL sequence.
    always_comb begin
        // NOTE: every *_d gets its hold value first, so branches that do not
        // touch a signal cannot infer a latch.
        state_d  = state_q;
        work_d   = work_q;
        saved_d  = saved_q;
        dr_d     = dr_q;
        dr_ctr_d = dr_ctr_q;
        qr_idx_d = qr_idx_q;
        valid_d  = valid_q;
        out_d    = out_q;

        case (state_q)
            IDLE: begin
                if (init) begin
                    for (int i = 0; i < 16; i++) begin
                        work_d[i]  = state_in[511-32*i -: 32];
                        saved_d[i] = state_in[511-32*i -: 32];
                    end
                    dr_d     = rounds[4:1];
                    valid_d  = 1'b0;
                    qr_idx_d = 3'd0;
                    dr_ctr_d = 4'd0;
                    state_d  = (rounds[4:1] == 4'd0) ? FINAL : ROUNDS;
                end
            end

            ROUNDS: begin
                work_d[ia] = qa;
                work_d[ib] = qb;
                work_d[ic] = qc;
                work_d[id] = qd;
                qr_idx_d   = qr_idx_q + 3'd1;
                if (qr_idx_q == 3'd7) begin
                    dr_ctr_d = dr_ctr_q + 4'd1;
                    if (dr_ctr_q == dr_q - 4'd1) begin
                        state_d = FINAL;
                    end
                end
            end

            FINAL: begin
                for (int i = 0; i < 16; i++) begin
                    out_d[511-32*i -: 32] = work_q[i] + saved_q[i];
                end
                valid_d = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the working and saved state are ordinary flops (not a RAM),
            // and they are cleared on reset so no prior block leaks out.
            state_q  <= IDLE;
            work_q   <= '0;
            saved_q  <= '0;
            dr_q     <= 4'd0;
            dr_ctr_q <= 4'd0;
            qr_idx_q <= 3'd0;
            valid_q  <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            saved_q  <= saved_d;
            dr_q     <= dr_d;
            dr_ctr_q <= dr_ctr_d;
            qr_idx_q <= qr_idx_d;
            valid_q  <= valid_d;
            out_q    <= out_d;
        end
    end

endmodule

// File: tb/tb_chacha_round_ctrl.sv
// Self-checking bench for chacha_round_ctrl: directed RFC 7539 vectors,
// edge cases and randomized blocks checked against a word-array model.

module tb_chacha_round_ctrl;

    typedef logic [15:0][31:0] words_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         init;
    logic [4:0]   rounds;
    logic [511:0] state_in;
    logic         ready;
    logic         valid;
    logic [511:0] state_out;

    int checks = 0;
    int errors = 0;

    chacha_round_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .rounds    (rounds),
        .state_in  (state_in),
        .ready     (ready),
        .valid     (valid),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    localparam logic [511:0] RFC_IN = {
        32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
        32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
        32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
        32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic void qround(inout words_t x, input int a, input int b, input int c, input int d);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
    endfunction

    function automatic logic [511:0] ref_block(input logic [511:0] s, input logic [4:0] r);
        words_t       in_w, x;
        logic [511:0] res;
        int           dr;
        dr = int'(r) / 2;
        for (int i = 0; i < 16; i++) in_w[i] = s[511-32*i -: 32];
        x = in_w;
        for (int k = 0; k < dr; k++) begin
            for (int i = 0; i < 4; i++) qround(x, i, 4 + i, 8 + i, 12 + i);
            for (int i = 0; i < 4; i++)
                qround(x, i, 4 + (i + 1) % 4, 8 + (i + 2) % 4, 12 + (i + 3) % 4);
        end
        for (int i = 0; i < 16; i++) res[511-32*i -: 32] = x[i] + in_w[i];
        return res;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Present init for one edge, then scramble the inputs so a running block
    // that re-sampled them would be caught.
    task automatic pulse_init(input logic [511:0] s, input logic [4:0] r);
        init     = 1'b1;
        state_in = s;
        rounds   = r;
        @(posedge clk); #1;
        init     = 1'b0;
        state_in = rand512();
        rounds   = 5'($urandom);
    endtask

    // Count edges until valid; optionally pulse a stray init at cycle poke_at;
    // report whether state_out stayed at its entry value while valid was low.
    task automatic wait_valid(input int limit, input int poke_at, output int lat, output bit stable);
        logic [511:0] entry;
        entry  = state_out;
        stable = 1'b1;
        lat    = 0;
        while (!valid && lat < limit) begin
            if (state_out !== entry) stable = 1'b0;
            init = (lat + 1 == poke_at);
            if (init) state_in = rand512();
            @(posedge clk); #1;
            lat++;
        end
        init = 1'b0;
        if (!valid) $display("FAIL timeout: valid not seen within %0d cycles", limit);
    endtask

    task automatic run_and_check(input string tag, input logic [511:0] s, input logic [4:0] r);
        int lat;
        bit st;
        logic [511:0] exp;
        exp = ref_block(s, r);
        pulse_init(s, r);
        wait_valid(200, -1, lat, st);
        check({tag, "_lat"}, 512'(lat), 512'(8 * (int'(r) / 2) + 1));
        check({tag, "_out"}, state_out, exp);
    endtask

    initial begin
        int           lat;
        bit           st;
        int           bad;
        logic [511:0] s, s2, exp, exp2, held;
        logic [4:0]   r;

        reset    = 1'b1;
        init     = 1'b1;
        rounds   = 5'd20;
        state_in = RFC_IN;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 512'(ready), 512'(1));
        check("rst_valid", 512'(valid), 512'(0));
        check("rst_out",   state_out, '0);
        reset = 1'b0;
        init  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ready_after_rst_init", 512'(ready), 512'(1));
        check("idle_valid", 512'(valid), 512'(0));

        // RFC 7539 2.3.2 block.
        exp = ref_block(RFC_IN, 5'd20);
        check("model_rfc_w0", 512'(exp[511 -: 32]), 512'(32'he4e7f110));
        check("model_rfc_w1", 512'(exp[479 -: 32]), 512'(32'h15593bd1));
        pulse_init(RFC_IN, 5'd20);
        check("busy_ready", 512'(ready), 512'(0));
        wait_valid(200, -1, lat, st);
        check("rfc_lat", 512'(lat), 512'(81));
        check("rfc_w0", 512'(state_out[511 -: 32]), 512'(32'he4e7f110));
        check("rfc_w1", 512'(state_out[479 -: 32]), 512'(32'h15593bd1));
        check("rfc_out", state_out, exp);
        @(posedge clk); #1;
        check("rfc_hold_valid", 512'(valid), 512'(1));
        check("rfc_hold_out", state_out, exp);

        // DR=0: doubled state, wraparound of 0x80000001.
        pulse_init({16{32'h80000001}}, 5'd0);
        wait_valid(20, -1, lat, st);
        check("dr0_lat", 512'(lat), 512'(1));
        check("dr0_out", state_out, {16{32'h00000002}});

        // rounds=8 with a stray init mid-run; rounds=9 matches rounds=8.
        s   = rand512();
        exp = ref_block(s, 5'd8);
        pulse_init(s, 5'd8);
        wait_valid(200, 10, lat, st);
        check("r8_poke_lat", 512'(lat), 512'(33));
        check("r8_poke_out", state_out, exp);
        pulse_init(s, 5'd9);
        wait_valid(200, -1, lat, st);
        check("r9_lat", 512'(lat), 512'(33));
        check("r9_out", state_out, exp);

        // Reset at cycle 40 of a 20-round block aborts it.
        pulse_init(rand512(), 5'd20);
        repeat (39) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_ready", 512'(ready), 512'(1));
        check("abort_valid", 512'(valid), 512'(0));
        check("abort_out", state_out, '0);
        bad = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (valid || !ready) bad++;
        end
        check("abort_quiet", 512'(bad), 512'(0));
        run_and_check("post_abort_rfc", RFC_IN, 5'd20);

        // Back-to-back: new init in the first valid cycle.
        s    = rand512();
        s2   = rand512();
        exp  = ref_block(s, 5'd12);
        exp2 = ref_block(s2, 5'd12);
        pulse_init(s, 5'd12);
        wait_valid(200, -1, lat, st);
        check("b2b_first_out", state_out, exp);
        held = state_out;
        pulse_init(s2, 5'd12);
        check("b2b_valid_drop", 512'(valid), 512'(0));
        check("b2b_held_out", state_out, held);
        wait_valid(200, -1, lat, st);
        check("b2b_hold_stable", 512'(st), 512'(1));
        check("b2b_lat", 512'(lat - 1), 512'(48));
        check("b2b_second_out", state_out, exp2);

        // Randomized blocks.
        for (int n = 0; n < 8; n++) begin
            r = 5'($urandom_range(0, 31));
            run_and_check($sformatf("rand%0d_r%0d", n, r), rand512(), r);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
